free_list_ctrl: RTL and testbench

Physical-register free-list controller for the renaming stage of the Tomasulo/P6 core. It hands out free physical tags to dispatch, which uses them for new rename-table mappings. It takes back the superseded tags released at commit. On a branch flush it rewinds all speculative allocations in one cycle. It is the allocator that sequences the RegisterRenaming table: the table never chooses a tag itself.

---
 rtl/free_list_ctrl_pkg.sv | 44 ++++
 rtl/free_list_ctrl_if.sv | 24 ++
 rtl/free_list_ctrl_fl_ptr.sv | 39 +++
 rtl/free_list_ctrl.sv | 85 ++++++++
 tb/tb_free_list_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/free_list_ctrl_pkg.sv
// Shared types and sizing for the physical-register free list.
package free_list_ctrl_pkg;

  localparam int NUM_ARCH_REG = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int FREE_N       = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int TAG_W        = $clog2(NUM_PHYS_REG);
  localparam int IDX_W        = $clog2(FREE_N);
  localparam int CNT_W        = IDX_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] count_t;

  // Circular-buffer pointer: slot index plus a wrap bit that toggles on each lap.
  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  localparam ptr_t PTR_ZERO   = '0;
  localparam ptr_t TAIL_RESET = {1'b1, {IDX_W{1'b0}}};

  // Advance a pointer by one slot, flipping the wrap bit at the end of the buffer.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    r = p;
    if (p.idx == IDX_W'(FREE_N - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + IDX_W'(1);
    end
    return r;
  endfunction

  // Number of slots from lo up to hi, modulo 2*FREE_N.
  function automatic count_t ptr_dist(input ptr_t hi, input ptr_t lo);
    if (hi.wrap == lo.wrap) begin
      return count_t'(hi.idx) - count_t'(lo.idx);
    end
    return count_t'(FREE_N) + count_t'(hi.idx) - count_t'(lo.idx);
  endfunction

endpackage

// File: rtl/free_list_ctrl_if.sv
// Dispatch/commit side of the free-list controller.
interface free_list_ctrl_if;
  import free_list_ctrl_pkg::*;

  logic   alloc_req;
  logic   alloc_valid;
  tag_t   alloc_tag;
  logic   commit;
  tag_t   commit_old_tag;
  logic   flush;
  count_t free_count;
  logic   error;

  modport master (
    output alloc_req, commit, commit_old_tag, flush,
    input  alloc_valid, alloc_tag, free_count, error
  );

  modport slave (
    input  alloc_req, commit, commit_old_tag, flush,
    output alloc_valid, alloc_tag, free_count, error
  );

endinterface

// File: rtl/free_list_ctrl_fl_ptr.sv
// Wrap-bit pointer register; a load takes priority over an increment.
module fl_ptr
  import free_list_ctrl_pkg::*;
#(
  parameter ptr_t RESET_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic load_i,
  input  ptr_t load_val_i,
  output ptr_t ptr_o
);

  ptr_t ptr_q;
  ptr_t ptr_d;

  // Choose the next pointer value: load, increment or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_inc(ptr_q);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= RESET_VAL;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: hands out tags at head, takes them back at tail,
// and rewinds head to the committed point on a flush.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  free_list_ctrl_if.slave  fl
);

  ptr_t   head;
  ptr_t   arch_head;
  ptr_t   tail;
  ptr_t   arch_head_d;
  tag_t   mem_q [FREE_N];
  logic   error_q;
  logic   error_d;
  count_t free_count;
  logic   alloc_fire;
  logic   commit_ok;
  logic   commit_err;

  // Decode which operations are legal this cycle; outputs depend only on state.
  always_comb begin
    free_count  = ptr_dist(tail, head);
    commit_err  = fl.commit && ((arch_head == head) || (free_count == count_t'(FREE_N)));
    commit_ok   = fl.commit && !commit_err;
    alloc_fire  = fl.alloc_req && (free_count != '0) && !fl.flush;
    arch_head_d = commit_ok ? ptr_inc(arch_head) : arch_head;
    error_d     = error_q | commit_err;
  end

  fl_ptr #(.RESET_VAL(PTR_ZERO)) u_head (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (alloc_fire),
    .load_i     (fl.flush),
    .load_val_i (arch_head_d),
    .ptr_o      (head)
  );

  fl_ptr #(.RESET_VAL(PTR_ZERO)) u_arch_head (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (commit_ok),
    .load_i     (1'b0),
    .load_val_i (PTR_ZERO),
    .ptr_o      (arch_head)
  );

  fl_ptr #(.RESET_VAL(TAIL_RESET)) u_tail (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (commit_ok),
    .load_i     (1'b0),
    .load_val_i (PTR_ZERO),
    .ptr_o      (tail)
  );

  // Tag storage: preloaded with the unmapped tags, refilled by commits at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FREE_N; i++) begin
        mem_q[i] <= tag_t'(NUM_ARCH_REG + i);
      end
    end else if (commit_ok) begin
      mem_q[tail.idx] <= fl.commit_old_tag;
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign fl.alloc_valid = (free_count != '0);
  assign fl.alloc_tag   = mem_q[head.idx];
  assign fl.free_count  = free_count;
  assign fl.error       = error_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed self-checking bench for free_list_ctrl.
module tb_free_list_ctrl;
  import free_list_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   failCount  = 0;

  free_list_ctrl_if flIf ();

  free_list_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .fl    (flIf)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic allocReq;
    logic commit;
    int   oldTag;
    logic flush;
    logic expValid;
    int   expTag;
    int   expCount;
    logic expError;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic v, input int t, input int c, input logic e);
    checkOutput({name, " valid"}, 32'(flIf.alloc_valid), 32'(v));
    checkOutput({name, " tag"},   32'(flIf.alloc_tag),   t);
    checkOutput({name, " count"}, 32'(flIf.free_count),  c);
    checkOutput({name, " error"}, 32'(flIf.error),       32'(e));
  endtask

  task automatic applyStimulus(input logic a, input logic c, input int t, input logic f);
    flIf.alloc_req      = a;
    flIf.commit         = c;
    flIf.commit_old_tag = tag_t'(t);
    flIf.flush          = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic allocN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    // Expected outputs are those visible in the row's cycle, before its edge.
    vecs[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 32, 32, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 33, 31, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 34, 30, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 35, 29, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 35, 29, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2, 1'b0, 1'b1, 35, 30, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 36, 30, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 34, 32, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 7, 1'b0, 1'b1, 34, 32, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 34, 32, 1'b1};

    // Table: allocs, commits, paired op, flush, then a commit with nothing outstanding.
    doReset();
    checkState("reset", 1'b1, 32, 32, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].allocReq, vecs[i].commit, vecs[i].oldTag, vecs[i].flush);
      checkState($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expTag,
                 vecs[i].expCount, vecs[i].expError);
      step();
    end

    // Error straight after reset is sticky and cleared only by reset.
    doReset();
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkState("errA", 1'b1, 32, 32, 1'b1);
    step();
    step();
    checkOutput("errA sticky", 32'(flIf.error), 1);
    doReset();
    checkState("errA cleared", 1'b1, 32, 32, 1'b0);

    // Drain the list, hold alloc_req while empty, then refill with one commit.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("drain tag", 32'(flIf.alloc_tag), 32 + i);
      checkOutput("drain count", 32'(flIf.free_count), 32 - i);
      step();
    end
    checkState("empty", 1'b0, 32, 0, 1'b0);
    step();
    checkState("empty held", 1'b0, 32, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    checkOutput("empty commit same cycle", 32'(flIf.alloc_valid), 0);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkState("refill", 1'b1, 5, 1, 1'b0);

    // Reset mid-operation, then paired alloc+commit keeps the count steady.
    doReset();
    allocN(12);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, i, 1'b0);
      checkOutput("pair count", 32'(flIf.free_count), 20);
      checkOutput("pair tag", 32'(flIf.alloc_tag), 44 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("fifo tag", 32'(flIf.alloc_tag), (i < 10) ? (54 + i) : (i - 10));
      checkOutput("fifo count", 32'(flIf.free_count), 20 - i);
      step();
    end
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    // Alloc 6, commit two, flush: list regains the four uncommitted tags.
    doReset();
    allocN(6);
    applyStimulus(1'b0, 1'b1, 1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 2, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkState("flush", 1'b1, 34, 32, 1'b0);

    // Flush with a same-cycle commit and alloc: commit counts, alloc is dropped.
    doReset();
    allocN(4);
    applyStimulus(1'b1, 1'b1, 9, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkState("flush+commit", 1'b1, 33, 32, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkState("flush+commit next", 1'b1, 34, 31, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
